// File: rtl/nibble_add_seq.sv
// nibble_add_seq: sequential W-bit adder that ripples one 4-bit nibble per clock, valid/ready on both sides.
// Optional overflow output enabled by defining NIBBLE_ADD_OVF_EN.
module nibble_add_seq #(
  parameter int NNIB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NNIB-1:0] x,
  input  logic [4*NNIB-1:0] y,
  input  logic              cy_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NNIB-1:0] s,
  output logic              cy_out
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic              ovf
`endif
);
  localparam int W = 4 * NNIB;
  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic carry_q, carry_d;
  logic cy_q, cy_d;
  logic [W-1:0] xa_q, xa_d, ya_q, ya_d, s_q, s_d;
  logic [3:0] xn, yn;
  logic [4:0] sum;
`ifdef NIBBLE_ADD_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign s         = s_q;
  assign cy_out    = cy_q;
  always_comb begin
    xn = '0;
    yn = '0;
    for (int i = 0; i < NNIB; i++) begin
      if (k_q == 3'(i)) begin
        xn = xa_q[4*i +: 4];
        yn = ya_q[4*i +: 4];
      end
    end
    sum = {1'b0, xn} + {1'b0, yn} + {4'b0, carry_q};
  end
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    cy_d    = cy_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    s_d     = s_q;
`ifdef NIBBLE_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        xa_d    = x;
        ya_d    = y;
        carry_d = cy_in;
        k_d     = '0;
        state_d = ADD;
      end
      ADD: begin
        for (int i = 0; i < NNIB; i++) s_d[4*i +: 4] = (k_q == 3'(i)) ? sum[3:0] : s_q[4*i +: 4];
        carry_d = sum[4];
        k_d     = k_q + 3'd1;
        if (k_q == 3'(NNIB - 1)) begin
          cy_d    = sum[4];
          state_d = HOLD;
`ifdef NIBBLE_ADD_OVF_EN
          // Same-sign operands producing an opposite-sign result is exactly carry-in(MSB) xor carry-out(MSB).
          ovf_d   = (xn[3] ~^ yn[3]) & (sum[3] ^ xn[3]);
`endif
        end
      end
      HOLD: state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      cy_q    <= 1'b0;
      xa_q    <= '0;
      ya_q    <= '0;
      s_q     <= '0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cy_q    <= cy_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      s_q     <= s_d;
`ifdef NIBBLE_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed-vector bench for nibble_add_seq with NNIB=4.
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic cy_in = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] s;
  logic cy_out;
`ifdef NIBBLE_ADD_OVF_EN
  logic ovf;
`endif
  int n_tests = 0;
  int n_fail = 0;
  nibble_add_seq #(.NNIB(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cy_in(cy_in), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cy_out(cy_out)
`ifdef NIBBLE_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [15:0] xv, input logic [15:0] yv, input logic ci,
                     input logic [15:0] es, input logic ec, input string tag);
    int n;
    x = xv; y = yv; cy_in = ci; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_s"}, 32'(s), 32'(es));
    chk({tag, "_cy"}, 32'(cy_out), 32'(ec));
    tick();
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_keep"}, 32'(s), 32'(es));
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_cy", 32'(cy_out), 32'd0);
    run(16'h0000, 16'h0001, 1'b1, 16'h0002, 1'b0, "basic");
    run(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple1");
    run(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, "ripple2");
    run(16'h8421, 16'h8421, 1'b1, 16'h0843, 1'b1, "mixed");
    // Backpressure: result held while new operands are offered.
    x = 16'h1234; y = 16'h1111; cy_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    x = 16'hDEAD; y = 16'h0001;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_s", 32'(s), 32'h2345);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    x = 16'h0101; y = 16'h0202; out_ready = 1'b1;
    tick();
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_no_same_cycle", 32'(s), 32'h2345);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_s", 32'(s), 32'h0303);
    tick();
    // Reset on the second ADD edge.
    x = 16'hAAAA; y = 16'h5555; cy_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_idle", 32'(in_ready), 32'd1);
    chk("mid_rst_s", 32'(s), 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, "after_rst");
`ifdef NIBBLE_ADD_OVF_EN
    run(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf1");
    chk("ovf1_flag", 32'(ovf), 32'd1);
    run(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, "ovf2");
    chk("ovf2_flag", 32'(ovf), 32'd1);
    run(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ovf3");
    chk("ovf3_flag", 32'(ovf), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
